truth_table_checker: RTL and testbench

- Exhaustive, parametrised tester for a combinational circuit-under-test (CUT) with N_IN inputs and N_OUT outputs.
- On start, it sweeps every input vector 0..2^N_IN-1 onto the CUT and waits a programmable settle time per vector.
- It compares the CUT outputs against an expected truth table and reports pass/fail, the mismatch count and the first failing vector.
- It sits beside the lab gate-level circuits as their self-checking harness on the FPGA board.

---
 rtl/truth_table_checker.sv | 130 +++++++++++++
 tb/tb_truth_table_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table tester: sweeps every input vector onto a combinational CUT,
// waits SETTLE extra cycles per vector, then compares the response with a captured table.
module truth_table_checker #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop_on_fail,
    input  logic [(2**N_IN)*N_OUT-1:0]  exp_table,
    output logic [N_IN-1:0]             cut_in,
    input  logic [N_OUT-1:0]            cut_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_count,
    output logic [N_IN-1:0]             first_fail_vec,
    output logic [N_OUT-1:0]            first_fail_got
);

    localparam int TW = (2**N_IN)*N_OUT;
    localparam int CW = 4;
    localparam int EW = N_IN + 1;

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     table_q, table_d;
    logic              stop_q, stop_d;
    logic [N_IN-1:0]   cut_in_q, cut_in_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [EW-1:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic [N_OUT-1:0]  ffg_q, ffg_d;
    logic [N_OUT-1:0]  exp_entry;
    logic              mismatch;

    always_comb begin
        state_d   = state_q;
        table_d   = table_q;
        stop_d    = stop_q;
        cut_in_d  = cut_in_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffg_d     = ffg_q;
        exp_entry = table_q[int'(cut_in_q)*N_OUT +: N_OUT];
        mismatch  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    table_d  = exp_table;
                    stop_d   = stop_on_fail;
                    err_d    = '0;
                    ffv_d    = '0;
                    ffg_d    = '0;
                    pass_d   = 1'b0;
                    cut_in_d = '0;
                    cnt_d    = CW'(SETTLE);
                    state_d  = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    mismatch = (cut_out != exp_entry);
                    if (mismatch) begin
                        err_d = err_q + EW'(1);
                        // Only the very first mismatch of the sweep is recorded.
                        if (err_q == '0) begin
                            ffv_d = cut_in_q;
                            ffg_d = cut_out;
                        end
                    end
                    if (cut_in_q == {N_IN{1'b1}} || (mismatch && stop_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        cut_in_d = cut_in_q + N_IN'(1);
                        cnt_d    = CW'(SETTLE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            table_q  <= '0;
            stop_q   <= 1'b0;
            cut_in_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= '0;
            ffg_q    <= '0;
        end else begin
            state_q  <= state_d;
            table_q  <= table_d;
            stop_q   <= stop_d;
            cut_in_q <= cut_in_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffg_q    <= ffg_d;
        end
    end

    assign cut_in         = cut_in_q;
    assign busy           = (state_q == APPLY);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_got = ffg_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed plan plus random CUT/table pairs,
// checked against a per-vector sweep model.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (SETTLE=1) driven by a lookup-table CUT
    logic        start, stop_on_fail;
    logic [15:0] exp_table, cut_tab;
    logic [3:0]  cut_in, first_fail_vec;
    logic        cut_out, busy, done, pass, first_fail_got;
    logic [4:0]  err_count;
    assign cut_out = cut_tab[cut_in];

    truth_table_checker #(.N_IN(4), .N_OUT(1), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_on_fail(stop_on_fail),
        .exp_table(exp_table), .cut_in(cut_in), .cut_out(cut_out), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got));

    // Second DUT (SETTLE=0) with a pure XOR CUT
    logic        start0, stop0;
    logic [15:0] exp0;
    logic [3:0]  cut_in0, ffv0;
    logic        cut_out0, busy0, done0, pass0, ffg0;
    logic [4:0]  err0;
    assign cut_out0 = ^cut_in0;

    truth_table_checker #(.N_IN(4), .N_OUT(1), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop_on_fail(stop0),
        .exp_table(exp0), .cut_in(cut_in0), .cut_out(cut_out0), .busy(busy0),
        .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_got(ffg0));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: walk the vectors in order, count differences, stop early if asked.
    task automatic model(input logic [15:0] ex, input logic [15:0] ct, input logic stp,
                         input int settle, output int errs, output int fv, output int fg,
                         output int last, output int lat);
        errs = 0; fv = 0; fg = 0; last = 15;
        for (int v = 0; v < 16; v++) begin
            if (ct[v] !== ex[v]) begin
                if (errs == 0) begin fv = v; fg = int'(ct[v]); end
                errs++;
                if (stp) begin last = v; break; end
            end
        end
        lat = (last + 1) * (settle + 1) + 1;
    endtask

    // Cycles are counted at falling edges after the start edge until done is seen.
    task automatic run(input logic [15:0] ex, input logic stp, output int cyc, output logic b1);
        @(negedge clk);
        exp_table = ex; stop_on_fail = stp; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1; b1 = busy;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    endtask

    task automatic sweep_and_check(input string tag, input logic [15:0] ex, input logic stp);
        int cyc, errs, fv, fg, last, lat;
        logic b1;
        model(ex, cut_tab, stp, 1, errs, fv, fg, last, lat);
        run(ex, stp, cyc, b1);
        check({tag, ".busy"}, 32'(b1), 32'd1);
        check({tag, ".lat"}, cyc, lat);
        check({tag, ".pass"}, 32'(pass), 32'(errs == 0));
        check({tag, ".err"}, 32'(err_count), errs);
        check({tag, ".ffv"}, 32'(first_fail_vec), fv);
        check({tag, ".ffg"}, 32'(first_fail_got), fg);
        check({tag, ".cut_in"}, 32'(cut_in), last);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".pass_held"}, 32'(pass), 32'(errs == 0));
    endtask

    initial begin
        int cyc;
        logic [15:0] mask;
        logic stp;
        start = 1'b0; stop_on_fail = 1'b0; exp_table = '0; cut_tab = 16'h6996;
        start0 = 1'b0; stop0 = 1'b0; exp0 = 16'h6996;

        #1;
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.pass", 32'(pass), 0);
        check("rst.err", 32'(err_count), 0);
        check("rst.cut_in", 32'(cut_in), 0);
        check("rst.ffv", 32'(first_fail_vec), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sweep_and_check("xor_ok", 16'h6996, 1'b0);
        sweep_and_check("entry0_bad", 16'h6997, 1'b0);
        sweep_and_check("two_bad", 16'h6996 ^ 16'h0120, 1'b0);
        sweep_and_check("two_bad_stop", 16'h6996 ^ 16'h0120, 1'b1);

        // SETTLE=0: one vector per cycle
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; cyc = 1;
        while (!done0 && cyc < 100) begin
            if (cyc <= 16) check("s0.cut_in", 32'(cut_in0), cyc - 1);
            @(negedge clk); cyc++;
        end
        check("s0.lat", cyc, 17);
        check("s0.pass", 32'(pass0), 1);
        check("s0.err", 32'(err0), 0);
        check("s0.cut_in_last", 32'(cut_in0), 15);

        // Start re-pulse and table change mid-sweep must be ignored
        @(negedge clk); exp_table = 16'h6996; stop_on_fail = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 4) begin start = 1'b1; exp_table = 16'h0000; stop_on_fail = 1'b1; end
            if (cyc == 5) start = 1'b0;
            @(negedge clk); cyc++;
        end
        check("mid.lat", cyc, 33);
        check("mid.pass", 32'(pass), 1);
        check("mid.err", 32'(err_count), 0);

        // Start while in DONE restarts at once
        start = 1'b1; exp_table = 16'h6996; stop_on_fail = 1'b0;
        @(negedge clk); start = 1'b0;
        check("redo.busy", 32'(busy), 1);
        check("redo.pass_clr", 32'(pass), 0);
        cyc = 1;
        while (!done && cyc < 200) begin @(negedge clk); cyc++; end
        check("redo.lat", cyc, 33);

        // Reset at vector 7
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 0;
        while (cut_in != 4'd7 && cyc < 200) begin @(negedge clk); cyc++; end
        check("rst7.reached", 32'(cut_in), 7);
        rst_n = 1'b0;
        #1;
        check("rst7.cut_in", 32'(cut_in), 0);
        check("rst7.busy", 32'(busy), 0);
        check("rst7.pass", 32'(pass), 0);
        check("rst7.err", 32'(err_count), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst7.no_done", 32'(done), 0);
        check("rst7.idle", 32'(busy), 0);
        sweep_and_check("after_rst", 16'h6996, 1'b0);

        // Random CUT behaviour and sparse table faults
        for (int i = 0; i < 8; i++) begin
            cut_tab = 16'($urandom);
            mask = 16'($urandom & $urandom & $urandom);
            if (i % 3 == 0) mask = '0;
            stp = 1'($urandom_range(0, 1));
            sweep_and_check("rand", cut_tab ^ mask, stp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
